// File: rtl/mmcm_lock_sequencer.sv
// MMCM reset/power-down sequencer with lock debounce and bounded retries.
// Drives MMCM RST/PWRDWN and reports filtered ready or sticky fail.
module mmcm_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_FILTER  = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pwrdwn_req,
  input  logic       locked_in,
  output logic       mmcm_rst,
  output logic       mmcm_pwrdwn,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_lock_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_LOCKED = 3'd3,
    S_PWRDN  = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [19:0] RST_LAST = 20'(RST_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  FL_LAST  = 8'(LOCK_FILTER - 1);
  localparam logic [3:0]  R_MAX    = 4'(MAX_RETRIES);

  state_t      r_state;
  state_t      w_nxt;
  logic        r_sync1;
  logic        r_lk;
  logic [19:0] r_tmr;
  logic [19:0] w_tmr;
  logic [7:0]  r_flt;
  logic [7:0]  w_flt;
  logic [3:0]  r_retry;
  logic [3:0]  w_retry;
  logic [7:0]  r_lost;
  logic [7:0]  w_lost;
  logic        r_mrst;
  logic        r_mpd;
  logic        r_rdy;
  logic        r_fail;

  always_comb begin
    w_nxt   = r_state;
    w_retry = r_retry;
    w_lost  = r_lost;
    w_tmr   = r_tmr + 20'd1;
    w_flt   = r_lk ? r_flt + 8'd1 : 8'd0;
    unique case (r_state)
      S_IDLE: begin
        if (pwrdwn_req) begin
          w_nxt = S_PWRDN;
        end else if (start) begin
          w_nxt   = S_RESET;
          w_retry = '0;
        end
      end
      S_RESET: begin
        if (pwrdwn_req)            w_nxt = S_PWRDN;
        else if (r_tmr == RST_LAST) w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (pwrdwn_req) begin
          w_nxt = S_PWRDN;
        end else if (r_lk && r_flt == FL_LAST) begin
          // lock beats a coincident timeout
          w_nxt = S_LOCKED;
        end else if (r_tmr == TO_LAST) begin
          if (r_retry == R_MAX) begin
            w_nxt = S_FAIL;
          end else begin
            w_nxt   = S_RESET;
            w_retry = r_retry + 4'd1;
          end
        end
      end
      S_LOCKED: begin
        if (pwrdwn_req) begin
          w_nxt = S_PWRDN;
        end else if (!r_lk) begin
          w_nxt   = S_RESET;
          w_retry = '0;
          if (r_lost != 8'hFF) w_lost = r_lost + 8'd1;
        end
      end
      S_PWRDN: begin
        if (!pwrdwn_req) begin
          w_nxt   = S_RESET;
          w_retry = '0;
        end
      end
      S_FAIL: begin
        if (start) begin
          w_nxt   = S_RESET;
          w_retry = '0;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_nxt != r_state) begin
      w_tmr = '0;
      w_flt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_lk    <= 1'b0;
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_flt   <= '0;
      r_retry <= '0;
      r_lost  <= '0;
      r_mrst  <= 1'b1;
      r_mpd   <= 1'b0;
      r_rdy   <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_sync1 <= locked_in;
      r_lk    <= r_sync1;
      r_state <= w_nxt;
      r_tmr   <= w_tmr;
      r_flt   <= w_flt;
      r_retry <= w_retry;
      r_lost  <= w_lost;
      r_mrst  <= (w_nxt == S_IDLE) || (w_nxt == S_RESET) ||
                 (w_nxt == S_PWRDN) || (w_nxt == S_FAIL);
      r_mpd   <= (w_nxt == S_PWRDN);
      r_rdy   <= (w_nxt == S_LOCKED);
      r_fail  <= (w_nxt == S_FAIL);
    end
  end

  assign mmcm_rst      = r_mrst;
  assign mmcm_pwrdwn   = r_mpd;
  assign ready         = r_rdy;
  assign fail          = r_fail;
  assign retry_cnt     = r_retry;
  assign lost_lock_cnt = r_lost;
  assign state         = r_state;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Scoreboard bench for mmcm_lock_sequencer: directed cycle-stamped vectors.
// Stimulus queues expected output snapshots; a negedge monitor checks them.
module tb_mmcm_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pwrdwn_req = 1'b0;
  logic       locked_in = 1'b0;
  logic       mmcm_rst;
  logic       mmcm_pwrdwn;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_lock_cnt;
  logic [2:0] state;

  mmcm_lock_sequencer #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .LOCK_FILTER(3),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pwrdwn_req(pwrdwn_req),
    .locked_in(locked_in),
    .mmcm_rst(mmcm_rst),
    .mmcm_pwrdwn(mmcm_pwrdwn),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .lost_lock_cnt(lost_lock_cnt),
    .state(state)
  );

  typedef struct {
    int          c;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cycle c means "just after posedge number c"
  task automatic ex(input int c, input int st, input int r,
                    input int p, input int rd, input int f,
                    input int rc, input int ll);
    exp_t e;
    e.c = c;
    e.v = {3'(st), 1'(r), 1'(p), 1'(rd), 1'(f), 4'(rc), 8'(ll)};
    sb.push_back(e);
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [18:0] got;
    got = {state, mmcm_rst, mmcm_pwrdwn, ready, fail,
           retry_cnt, lost_lock_cnt};
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      n_chk++;
      if (sb[0].c < cyc) begin
        n_fail++;
        $display("FAIL chk@%0d: not sampled (now %0d)", sb[0].c, cyc);
      end else if (got !== sb[0].v) begin
        n_fail++;
        $display("FAIL chk@%0d: got st=%0d rst=%b pd=%b rdy=%b fail=%b rc=%0d ll=%0d, required st=%0d rst=%b pd=%b rdy=%b fail=%b rc=%0d ll=%0d",
                 cyc, got[18:16], got[15], got[14], got[13], got[12],
                 got[11:8], got[7:0],
                 sb[0].v[18:16], sb[0].v[15], sb[0].v[14], sb[0].v[13],
                 sb[0].v[12], sb[0].v[11:8], sb[0].v[7:0]);
      end
      void'(sb.pop_front());
    end
  end

  initial begin
    // reset
    ex(1, 0, 1, 0, 0, 0, 0, 0);
    ex(2, 0, 1, 0, 0, 0, 0, 0);
    at(2);
    rst = 1'b0;

    // nominal lock
    ex(11, 1, 1, 0, 0, 0, 0, 0);
    ex(14, 1, 1, 0, 0, 0, 0, 0);
    ex(15, 2, 0, 0, 0, 0, 0, 0);
    ex(24, 2, 0, 0, 0, 0, 0, 0);
    ex(25, 3, 0, 0, 1, 0, 0, 0);
    at(10); start = 1'b1;
    at(11); start = 1'b0;
    at(20); locked_in = 1'b1;

    // one-cycle loss of lock, relock
    ex(32, 3, 0, 0, 1, 0, 0, 0);
    ex(33, 1, 1, 0, 0, 0, 0, 1);
    ex(36, 1, 1, 0, 0, 0, 0, 1);
    ex(37, 2, 0, 0, 0, 0, 0, 1);
    ex(39, 2, 0, 0, 0, 0, 0, 1);
    ex(40, 3, 0, 0, 1, 0, 0, 1);
    at(30); locked_in = 1'b0;
    at(31); locked_in = 1'b1;

    // lose lock for good, then power-down from WAIT_LOCK
    ex(45, 1, 1, 0, 0, 0, 0, 2);
    ex(49, 2, 0, 0, 0, 0, 0, 2);
    ex(53, 4, 1, 1, 0, 0, 0, 2);
    ex(56, 4, 1, 1, 0, 0, 0, 2);
    ex(57, 1, 1, 0, 0, 0, 0, 2);
    ex(60, 1, 1, 0, 0, 0, 0, 2);
    ex(61, 2, 0, 0, 0, 0, 0, 2);
    at(42); locked_in = 1'b0;
    at(52); pwrdwn_req = 1'b1;
    at(56); pwrdwn_req = 1'b0;

    // glitchy lock: 2 high, 1 low, then high
    ex(72, 2, 0, 0, 0, 0, 0, 2);
    ex(73, 3, 0, 0, 1, 0, 0, 2);
    at(65); locked_in = 1'b1;
    at(67); locked_in = 1'b0;
    at(68); locked_in = 1'b1;

    // retry exhaustion, stray start/pwrdwn ignored
    ex(78, 1, 1, 0, 0, 0, 0, 3);
    ex(81, 1, 1, 0, 0, 0, 0, 3);
    ex(82, 2, 0, 0, 0, 0, 0, 3);
    ex(113, 2, 0, 0, 0, 0, 0, 3);
    ex(114, 1, 1, 0, 0, 0, 1, 3);
    ex(118, 2, 0, 0, 0, 0, 1, 3);
    ex(149, 2, 0, 0, 0, 0, 1, 3);
    ex(150, 1, 1, 0, 0, 0, 2, 3);
    ex(154, 2, 0, 0, 0, 0, 2, 3);
    ex(185, 2, 0, 0, 0, 0, 2, 3);
    ex(186, 5, 1, 0, 0, 1, 2, 3);
    ex(190, 5, 1, 0, 0, 1, 2, 3);
    ex(193, 1, 1, 0, 0, 0, 0, 3);
    at(75); locked_in = 1'b0;
    at(90); start = 1'b1;
    at(91); start = 1'b0;
    at(188); pwrdwn_req = 1'b1;
    at(190); pwrdwn_req = 1'b0;
    at(192); start = 1'b1;

    // relock, then rst in LOCKED
    ex(200, 3, 0, 0, 1, 0, 0, 3);
    ex(202, 3, 0, 0, 1, 0, 0, 3);
    ex(203, 0, 1, 0, 0, 0, 0, 0);
    ex(204, 0, 1, 0, 0, 0, 0, 0);
    at(193); start = 1'b0; locked_in = 1'b1;
    at(202); rst = 1'b1;
    at(204); rst = 1'b0;

    at(212);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
